// File: rtl/key_char_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_char_ctrl_pkg                                                    |
// | Shared scan codes, ASCII codes and caps-lock state encodings.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package key_char_ctrl_pkg;

  localparam logic [8:0] SC_CAPS   = 9'h058;
  localparam logic [8:0] SC_LSHIFT = 9'h012;
  localparam logic [8:0] SC_RSHIFT = 9'h059;
  localparam logic [8:0] SC_ENTER  = 9'h05A;
  localparam logic [8:0] SC_BKSP   = 9'h066;
  localparam logic [8:0] SC_SPACE  = 9'h029;

  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_SP = 8'h20;

  typedef enum logic [0:0] {
    CAPS_L = 1'b0,
    CAPS_U = 1'b1
  } caps_state_e;

endpackage
`default_nettype wire

// File: rtl/key_char_ctrl_scan2ascii.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_char_ctrl_scan2ascii                                             |
// | Combinational scan2ascii: set-2 scan code to printable ASCII.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_char_ctrl_scan2ascii
  import key_char_ctrl_pkg::*;
(
  input  logic [8:0] code,
  input  logic       upper,
  output logic [7:0] ascii,
  output logic       is_char
);

  logic [7:0] w_letter;
  logic [7:0] w_other;
  logic       w_other_hit;

  // Letters are held in upper case; lower case is derived by setting bit 5.
  always_comb begin
    w_letter = 8'h00;
    case (code)
      9'h01C: w_letter = 8'h41;
      9'h032: w_letter = 8'h42;
      9'h021: w_letter = 8'h43;
      9'h023: w_letter = 8'h44;
      9'h024: w_letter = 8'h45;
      9'h02B: w_letter = 8'h46;
      9'h034: w_letter = 8'h47;
      9'h033: w_letter = 8'h48;
      9'h043: w_letter = 8'h49;
      9'h03B: w_letter = 8'h4A;
      9'h042: w_letter = 8'h4B;
      9'h04B: w_letter = 8'h4C;
      9'h03A: w_letter = 8'h4D;
      9'h031: w_letter = 8'h4E;
      9'h044: w_letter = 8'h4F;
      9'h04D: w_letter = 8'h50;
      9'h015: w_letter = 8'h51;
      9'h02D: w_letter = 8'h52;
      9'h01B: w_letter = 8'h53;
      9'h02C: w_letter = 8'h54;
      9'h03C: w_letter = 8'h55;
      9'h02A: w_letter = 8'h56;
      9'h01D: w_letter = 8'h57;
      9'h022: w_letter = 8'h58;
      9'h035: w_letter = 8'h59;
      9'h01A: w_letter = 8'h5A;
      default: w_letter = 8'h00;
    endcase
  end

  always_comb begin
    w_other     = 8'h00;
    w_other_hit = 1'b0;
    case (code)
      9'h045:   {w_other_hit, w_other} = {1'b1, 8'h30};
      9'h016:   {w_other_hit, w_other} = {1'b1, 8'h31};
      9'h01E:   {w_other_hit, w_other} = {1'b1, 8'h32};
      9'h026:   {w_other_hit, w_other} = {1'b1, 8'h33};
      9'h025:   {w_other_hit, w_other} = {1'b1, 8'h34};
      9'h02E:   {w_other_hit, w_other} = {1'b1, 8'h35};
      9'h036:   {w_other_hit, w_other} = {1'b1, 8'h36};
      9'h03D:   {w_other_hit, w_other} = {1'b1, 8'h37};
      9'h03E:   {w_other_hit, w_other} = {1'b1, 8'h38};
      9'h046:   {w_other_hit, w_other} = {1'b1, 8'h39};
      SC_ENTER: {w_other_hit, w_other} = {1'b1, ASCII_CR};
      SC_SPACE: {w_other_hit, w_other} = {1'b1, ASCII_SP};
      default:  {w_other_hit, w_other} = {1'b0, 8'h00};
    endcase
  end

  assign is_char = (w_letter != 8'h00) || w_other_hit;
  assign ascii   = (w_letter != 8'h00) ? (upper ? w_letter : (w_letter | 8'h20))
                                       : w_other;

endmodule
`default_nettype wire

// File: rtl/key_char_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_char_ctrl                                                        |
// | Keyboard press events to ASCII stream: caps FSM, character FIFO.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_char_ctrl
  import key_char_ctrl_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          fcrystal,
  input  logic          rst_n,
  input  logic [511:0]  key_down,
  input  logic [8:0]    last_change,
  input  logic          key_valid,
  input  logic          char_ready,
  output logic [7:0]    char_data,
  output logic          char_valid,
  output logic          caps_lock,
  output logic [AW:0]   fifo_count,
  output logic          overflow
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic              r_ev_valid;
  logic [8:0]        r_ev_code;
  logic              r_ev_shift;
  logic              r_ev_caps;
  caps_state_e       r_caps_state;
  caps_state_e       w_caps_next;
  logic [7:0]        r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic [AW:0]       w_count_next;
  logic              r_overflow;
  logic [7:0]        w_ascii;
  logic              w_is_char;
  logic              w_pop;
  logic              w_bksp;
  logic              w_remove;
  logic              w_push_req;
  logic              w_push;
  logic [7:0]        w_push_data;

  // Stage 1: capture the press together with the modifiers in force at that edge.
  always_ff @(posedge fcrystal or negedge rst_n) begin
    if (!rst_n) begin
      r_ev_valid <= 1'b0;
      r_ev_code  <= 9'h000;
      r_ev_shift <= 1'b0;
      r_ev_caps  <= 1'b0;
    end else begin
      r_ev_valid <= key_valid && key_down[last_change];
      r_ev_code  <= last_change;
      r_ev_shift <= key_down[SC_LSHIFT] | key_down[SC_RSHIFT];
      r_ev_caps  <= (r_caps_state == CAPS_U);
    end
  end

  key_char_ctrl_scan2ascii u_scan2ascii (
    .code    (r_ev_code),
    .upper   (r_ev_caps ^ r_ev_shift),
    .ascii   (w_ascii),
    .is_char (w_is_char)
  );

  always_comb begin
    w_caps_next = r_caps_state;
    if (r_ev_valid && (r_ev_code == SC_CAPS))
      w_caps_next = (r_caps_state == CAPS_L) ? CAPS_U : CAPS_L;
  end

  always_ff @(posedge fcrystal or negedge rst_n) begin
    if (!rst_n) r_caps_state <= CAPS_L;
    else        r_caps_state <= w_caps_next;
  end

  // Backspace only erases an entry that survives this edge's pop; otherwise it is a character.
  always_comb begin
    w_pop        = (r_count != '0) && char_ready;
    w_bksp       = r_ev_valid && (r_ev_code == SC_BKSP);
    w_remove     = w_bksp && (r_count > {{AW{1'b0}}, w_pop});
    w_push_req   = (r_ev_valid && w_is_char) || (w_bksp && !w_remove);
    w_push_data  = w_is_char ? w_ascii : ASCII_BS;
    w_push       = w_push_req && ((r_count != c_depth) || w_pop);
    w_count_next = r_count;
    if (w_push)   w_count_next = w_count_next + (AW+1)'(1);
    if (w_pop)    w_count_next = w_count_next - (AW+1)'(1);
    if (w_remove) w_count_next = w_count_next - (AW+1)'(1);
  end

  always_ff @(posedge fcrystal) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_data;
  end

  always_ff @(posedge fcrystal or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push)        r_wr_ptr <= r_wr_ptr + AW'(1);
      else if (w_remove) r_wr_ptr <= r_wr_ptr - AW'(1);
      if (w_pop)         r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_next;
      r_overflow <= r_overflow | (w_push_req && !w_push);
    end
  end

  assign char_valid = (r_count != '0);
  assign char_data  = char_valid ? r_mem[r_rd_ptr] : 8'h00;
  assign caps_lock  = (r_caps_state == CAPS_U);
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_key_char_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_key_char_ctrl                                                     |
// | Directed stimulus with a queue scoreboard checked by a monitor.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_key_char_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          fcrystal = 1'b0;
  logic          rst_n = 1'b0;
  logic [511:0]  key_down = '0;
  logic [8:0]    last_change = '0;
  logic          key_valid = 1'b0;
  logic          char_ready = 1'b0;
  logic [7:0]    char_data;
  logic          char_valid;
  logic          caps_lock;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [7:0]    exp_q[$];
  logic [7:0]    mon_exp;
  logic          track = 1'b0;
  int            max_cnt = 0;

  always #5 fcrystal = ~fcrystal;

  key_char_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .fcrystal    (fcrystal),
    .rst_n       (rst_n),
    .key_down    (key_down),
    .last_change (last_change),
    .key_valid   (key_valid),
    .char_ready  (char_ready),
    .char_data   (char_data),
    .char_valid  (char_valid),
    .caps_lock   (caps_lock),
    .fifo_count  (fifo_count),
    .overflow    (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted character is compared against the scoreboard head.
  always @(negedge fcrystal) begin
    if (rst_n && char_valid && char_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_char: got 0x%0h, expected none", char_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("char_data", {24'h0, char_data}, {24'h0, mon_exp});
      end
    end
    if (track && (int'(fifo_count) > max_cnt)) max_cnt = int'(fifo_count);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge fcrystal);
    #1;
  endtask

  task automatic press(input logic [8:0] code, input logic shift);
    key_down[code] = 1'b1;
    if (shift) key_down[9'h012] = 1'b1;
    last_change = code;
    key_valid   = 1'b1;
    @(posedge fcrystal);
    #1;
    key_valid        = 1'b0;
    key_down[code]   = 1'b0;
    key_down[9'h012] = 1'b0;
  endtask

  task automatic release_ev(input logic [8:0] code);
    key_down[code] = 1'b0;
    last_change    = code;
    key_valid      = 1'b1;
    @(posedge fcrystal);
    #1;
    key_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    char_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !char_valid) break;
      cyc(1);
    end
    check({name, "_queue_left"}, exp_q.size(), 0);
    check({name, "_valid_after"}, {31'h0, char_valid}, 0);
    char_ready = 1'b0;
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    cyc(2);
    check({name, "_count"},    {29'h0, fifo_count}, 0);
    check({name, "_valid"},    {31'h0, char_valid}, 0);
    check({name, "_data"},     {24'h0, char_data},  0);
    check({name, "_caps"},     {31'h0, caps_lock},  0);
    check({name, "_overflow"}, {31'h0, overflow},   0);
    exp_q.delete();
    rst_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    cyc(1);
    do_reset("rst");

    // Single lower-case letter and its two-cycle latency
    char_ready = 1'b0;
    exp_q.push_back(8'h61);
    press(9'h01C, 1'b0);
    check("t1_valid_early", {31'h0, char_valid}, 0);
    cyc(1);
    check("t1_valid", {31'h0, char_valid}, 1);
    check("t1_data",  {24'h0, char_data},  32'h61);
    check("t1_count", {29'h0, fifo_count}, 1);

    // Caps toggling, caps^shift, shift alone, extended code ignored
    press(9'h058, 1'b0);
    cyc(1);
    check("t2_caps_on", {31'h0, caps_lock}, 1);
    check("t2_caps_nopush", {29'h0, fifo_count}, 1);
    exp_q.push_back(8'h61);
    press(9'h01C, 1'b1);
    press(9'h058, 1'b0);
    cyc(1);
    check("t2_caps_off", {31'h0, caps_lock}, 0);
    exp_q.push_back(8'h51);
    press(9'h015, 1'b1);
    press(9'h11C, 1'b0);
    cyc(1);
    check("t2_count", {29'h0, fifo_count}, 3);
    drain("t2");

    // Fill past capacity: fifth digit dropped
    for (int i = 0; i < 4; i++) exp_q.push_back(8'h31 + 8'(i));
    press(9'h016, 1'b0);
    press(9'h01E, 1'b0);
    press(9'h026, 1'b0);
    press(9'h025, 1'b0);
    press(9'h02E, 1'b0);
    cyc(1);
    check("t3_count",    {29'h0, fifo_count}, 4);
    check("t3_overflow", {31'h0, overflow},   1);
    drain("t3");

    // Backspace erases tail; on empty FIFO it becomes 0x08
    exp_q.push_back(8'h65);
    exp_q.push_back(8'h72);
    press(9'h024, 1'b0);
    press(9'h02D, 1'b0);
    press(9'h066, 1'b0);
    void'(exp_q.pop_back());
    cyc(1);
    check("t4_count_after_bs", {29'h0, fifo_count}, 1);
    drain("t4a");
    exp_q.push_back(8'h08);
    press(9'h066, 1'b0);
    cyc(1);
    check("t4_bs_empty_count", {29'h0, fifo_count}, 1);
    check("t4_bs_empty_data",  {24'h0, char_data},  32'h08);
    drain("t4b");
    // Single entry popped on the same edge the backspace acts: 0x08 is pushed
    exp_q.push_back(8'h61);
    press(9'h01C, 1'b0);
    cyc(1);
    exp_q.push_back(8'h08);
    press(9'h066, 1'b0);
    char_ready = 1'b1;
    drain("t4c");

    // Streaming with consumer always ready
    do_reset("t5rst");
    char_ready = 1'b1;
    max_cnt = 0;
    track = 1'b1;
    exp_q.push_back(8'h30);
    press(9'h045, 1'b0);
    exp_q.push_back(8'h39);
    press(9'h046, 1'b0);
    exp_q.push_back(8'h20);
    press(9'h029, 1'b0);
    exp_q.push_back(8'h0D);
    press(9'h05A, 1'b0);
    drain("t5");
    track = 1'b0;
    check("t5_max_count", max_cnt, 1);
    check("t5_overflow", {31'h0, overflow}, 0);

    // Asynchronous reset mid-stream, then a release event
    char_ready = 1'b0;
    press(9'h058, 1'b0);
    press(9'h01C, 1'b0);
    press(9'h032, 1'b0);
    press(9'h021, 1'b0);
    cyc(1);
    check("t6_count_pre", {29'h0, fifo_count}, 3);
    check("t6_caps_pre",  {31'h0, caps_lock},  1);
    press(9'h01A, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async_count", {29'h0, fifo_count}, 0);
    check("t6_async_valid", {31'h0, char_valid}, 0);
    check("t6_async_caps",  {31'h0, caps_lock},  0);
    exp_q.delete();
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    check("t6_pending_cleared", {29'h0, fifo_count}, 0);
    release_ev(9'h01C);
    cyc(2);
    check("t6_release_count", {29'h0, fifo_count}, 0);
    check("t6_release_valid", {31'h0, char_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
